// File: rtl/gauss_filter_3x3.sv
// gauss_filter_3x3
// Streaming 3x3 Gaussian smoother. RGB input is reduced to 8-bit gray and
// filtered with [1 2 1;2 4 2;1 2 1]/16. Frame-border pixels pass through
// unfiltered. Exactly WIDTH*HEIGHT pixels leave per frame, in raster order.
// The 2*WIDTH+3 tap delay line is built from two WIDTH-deep line buffers
// (block RAM, registered read) and two window registers per row.
module gauss_filter_3x3 #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HSYNC_I,
  input  logic [7:0] DATA_R_I,
  input  logic [7:0] DATA_G_I,
  input  logic [7:0] DATA_B_I,
  output logic       HSYNC_O,
  output logic [7:0] DATA_R_O,
  output logic [7:0] DATA_G_O,
  output logic [7:0] DATA_B_O,
  output logic       filt_done
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int PTR_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  typedef enum logic [1:0] {FILL, RUN, FLUSH, DONE} state_t;

  state_t           state_reg, state_next;
  logic             push, emit, take_in;
  logic [CNT_W-1:0] in_cnt_reg, out_cnt_reg;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [15:0]      gray_sum;
  logic [7:0]       gray_y, push_y;
  logic [11:0]      kern_sum;
  logic             border;
  logic [7:0]       pix_out;
  logic             hsync_reg, done_reg;
  logic [7:0]       data_reg;

  // row_in[n] is the tap at delay n*WIDTH; tap_d1/tap_d2 are one and two pushes older
  logic [7:0] row_in [3];
  logic [7:0] tap_d1 [3];
  logic [7:0] tap_d2 [3];

  // FSM state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_reg <= FILL;
    else        state_reg <= state_next;
  end

  // FSM next state: FILL until the centre tap holds pixel 0, RUN for the rest
  // of the input, FLUSH to drain the last WIDTH+1 centres
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (HSYNC_I && in_cnt_reg == CNT_W'(WIDTH))    state_next = RUN;
      RUN:     if (HSYNC_I && in_cnt_reg == CNT_W'(NPIX - 1)) state_next = FLUSH;
      FLUSH:   if (out_cnt_reg == CNT_W'(NPIX - 1))           state_next = DONE;
      default: state_next = state_reg;
    endcase
  end

  // FSM outputs: when to shift the delay line and when a pixel is emitted
  always_comb begin
    push    = 1'b0;
    emit    = 1'b0;
    take_in = 1'b0;
    case (state_reg)
      FILL: begin
        push    = HSYNC_I;
        take_in = HSYNC_I;
      end
      RUN: begin
        push    = HSYNC_I;
        emit    = HSYNC_I;
        take_in = HSYNC_I;
      end
      FLUSH: begin
        push = 1'b1;
        emit = 1'b1;
      end
      default: ;
    endcase
  end

  // Gray conversion; flush cycles shift in zeros (they only reach bottom-row borders)
  always_comb begin
    gray_sum = 16'(DATA_R_I) * 16'd77 + 16'(DATA_G_I) * 16'd150 + 16'(DATA_B_I) * 16'd29;
    gray_y   = 8'(gray_sum >> 8);
    push_y   = take_in ? gray_y : 8'd0;
  end

  assign row_in[0] = push_y;

  // Line-buffer pointer; both buffers share it, advancing once per push
  always_comb begin
    ptr_next = ptr_reg;
    if (push) ptr_next = (ptr_reg == PTR_W'(WIDTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
  end

  // Pointer register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line_buf
      logic [7:0] mem [WIDTH];
      logic [7:0] rdata_reg;

      // Circular WIDTH-deep buffer. Reading at ptr_next keeps rdata_reg equal
      // to the value pushed WIDTH pushes before the next push.
      always_ff @(posedge HCLK) begin
        if (push) mem[ptr_reg] <= row_in[gi];
        rdata_reg <= mem[ptr_next];
      end

      assign row_in[gi+1] = rdata_reg;
    end

    for (gi = 0; gi < 3; gi++) begin : g_window
      logic [7:0] d1_reg, d2_reg;

      // Two-deep horizontal shift for one window row
      always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
          d1_reg <= 8'd0;
          d2_reg <= 8'd0;
        end else if (push) begin
          d1_reg <= row_in[gi];
          d2_reg <= d1_reg;
        end
      end

      assign tap_d1[gi] = d1_reg;
      assign tap_d2[gi] = d2_reg;
    end
  endgenerate

  // Kernel sum and border selection; tap_d1[1] is the centre pixel
  always_comb begin
    kern_sum = 12'(row_in[0]) + 12'(tap_d2[0]) + 12'(row_in[2]) + 12'(tap_d2[2])
             + ((12'(tap_d1[0]) + 12'(row_in[1]) + 12'(tap_d2[1]) + 12'(tap_d1[2])) << 1)
             + (12'(tap_d1[1]) << 2);
    border   = (row_reg == '0) || (row_reg == ROW_W'(HEIGHT - 1)) ||
               (col_reg == '0) || (col_reg == PTR_W'(WIDTH - 1));
    pix_out  = border ? tap_d1[1] : 8'(kern_sum >> 4);
  end

  // Input/output counters and centre-pixel coordinates
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
    end else begin
      if (take_in) in_cnt_reg <= in_cnt_reg + CNT_W'(1);
      if (emit) begin
        out_cnt_reg <= out_cnt_reg + CNT_W'(1);
        if (col_reg == PTR_W'(WIDTH - 1)) begin
          col_reg <= '0;
          row_reg <= row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + PTR_W'(1);
        end
      end
    end
  end

  // Registered outputs; data holds between pulses, done is sticky
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hsync_reg <= 1'b0;
      data_reg  <= 8'd0;
      done_reg  <= 1'b0;
    end else begin
      hsync_reg <= emit;
      if (emit) data_reg <= pix_out;
      if (state_reg == DONE) done_reg <= 1'b1;
    end
  end

  assign HSYNC_O   = hsync_reg;
  assign DATA_R_O  = data_reg;
  assign DATA_G_O  = data_reg;
  assign DATA_B_O  = data_reg;
  assign filt_done = done_reg;

endmodule
